// File: rtl/boot_hex_stream_loader.sv
// Boot loader that parses an ASCII hex stream into addressed words.
// Ports: clk, reset (async, high), in_char/in_valid in; out_address/out_data/out_valid/out_ready word out; busy, done, error status.
module boot_hex_stream_loader #(
  parameter int address_width  = 32,
  parameter int data_width     = 32,
  parameter int char_width     = 8,
  parameter int addr_increment = data_width / 8,
  parameter int timeout_cycles = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [char_width-1:0]    in_char,
  input  logic                     in_valid,
  output logic [address_width-1:0] out_address,
  output logic [data_width-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int AccW = (data_width > address_width) ?
                        data_width : address_width;
  localparam int DN   = data_width / 4;
  localparam int AN   = address_width / 4;
  localparam int CntW = $clog2(AccW / 4 + 2);
  localparam int TmrW = $clog2(timeout_cycles + 1);

  localparam logic [TmrW-1:0] TLOAD = TmrW'(timeout_cycles);
  localparam logic [TmrW-1:0] TONE  = TmrW'(1);
  localparam logic [address_width-1:0] AINC =
    address_width'(addr_increment);

  localparam logic [char_width-1:0] C_0   = char_width'(8'h30);
  localparam logic [char_width-1:0] C_9   = char_width'(8'h39);
  localparam logic [char_width-1:0] C_LA  = char_width'(8'h61);
  localparam logic [char_width-1:0] C_LF  = char_width'(8'h66);
  localparam logic [char_width-1:0] C_UA  = char_width'(8'h41);
  localparam logic [char_width-1:0] C_UF  = char_width'(8'h46);
  localparam logic [char_width-1:0] C_SP  = char_width'(8'h20);
  localparam logic [char_width-1:0] C_TAB = char_width'(8'h09);
  localparam logic [char_width-1:0] C_CR  = char_width'(8'h0d);
  localparam logic [char_width-1:0] C_NL  = char_width'(8'h0a);
  localparam logic [char_width-1:0] C_AT  = char_width'(8'h40);
  localparam logic [char_width-1:0] C_SL  = char_width'(8'h2f);

  typedef enum logic [2:0] {
    IDLE, DATA, ADDR, SLASH, COMMENT, ERR
  } state_t;

  state_t state_q, state_d;
  logic [AccW-1:0]          acc_q, acc_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic                     err_q, err_d;
  logic                     ov_q, ov_d;
  logic [data_width-1:0]    od_q, od_d;
  logic [address_width-1:0] oa_q, oa_d;
  logic                     done_q, done_d;
  logic [TmrW-1:0]          tmr_q, tmr_d;

  logic is_dig, is_hex, is_sep, is_at, is_slash, is_lf;
  logic [3:0] nib;
  logic [AccW-1:0] acc_sh;
  logic slot_free;

  // Letters a-f / A-F carry 1..6 in their low nibble, so +9 gives 10..15.
  always_comb begin
    is_dig   = (in_char >= C_0) && (in_char <= C_9);
    is_hex   = is_dig ||
               ((in_char >= C_LA) && (in_char <= C_LF)) ||
               ((in_char >= C_UA) && (in_char <= C_UF));
    is_lf    = (in_char == C_NL);
    is_sep   = (in_char == C_SP) || (in_char == C_TAB) ||
               (in_char == C_CR) || is_lf;
    is_at    = (in_char == C_AT);
    is_slash = (in_char == C_SL);
    nib      = is_dig ? in_char[3:0] : in_char[3:0] + 4'd9;
    acc_sh   = {acc_q[AccW-5:0], nib};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    ov_d      = ov_q;
    od_d      = od_q;
    oa_d      = oa_q;
    done_d    = 1'b0;
    tmr_d     = tmr_q;
    // A completing word may reuse the slot in the very cycle it drains.
    slot_free = !ov_q || out_ready;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (in_valid) begin
      tmr_d = TLOAD;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_hex: begin
              state_d = DATA;
              acc_d   = AccW'(nib);
              cnt_d   = CntW'(1);
            end
            is_at: begin
              state_d = ADDR;
              acc_d   = '0;
              cnt_d   = '0;
            end
            is_slash: state_d = SLASH;
            is_sep: begin end
            default: state_d = ERR;
          endcase
        end
        DATA: begin
          unique case (1'b1)
            is_hex: begin
              if (cnt_q == CntW'(DN)) state_d = ERR;
              else begin
                acc_d = acc_sh;
                cnt_d = cnt_q + CntW'(1);
              end
            end
            is_sep: begin
              if (slot_free) begin
                ov_d    = 1'b1;
                od_d    = acc_q[data_width-1:0];
                oa_d    = addr_q;
                addr_d  = addr_q + AINC;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
              end else begin
                state_d = ERR;
              end
            end
            default: state_d = ERR;
          endcase
        end
        ADDR: begin
          unique case (1'b1)
            is_hex: begin
              if (cnt_q == CntW'(AN)) state_d = ERR;
              else begin
                acc_d = acc_sh;
                cnt_d = cnt_q + CntW'(1);
              end
            end
            is_sep: begin
              if (cnt_q == '0) state_d = ERR;
              else begin
                addr_d  = acc_q[address_width-1:0];
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
              end
            end
            default: state_d = ERR;
          endcase
        end
        SLASH:   state_d = is_slash ? COMMENT : ERR;
        COMMENT: if (is_lf) state_d = IDLE;
        ERR:     begin end
        default: state_d = IDLE;
      endcase
      if (state_d == ERR) err_d = 1'b1;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TONE;
      if (tmr_q == TONE) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        addr_d  = '0;
        err_d   = 1'b0;
        done_d  = !err_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oa_q    <= '0;
      done_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oa_q    <= oa_d;
      done_q  <= done_d;
      tmr_q   <= tmr_d;
    end
  end

  assign out_address = oa_q;
  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign busy        = (tmr_q != '0);
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_boot_hex_stream_loader.sv
// Scoreboard bench for boot_hex_stream_loader.
// Directed stream cases plus random sessions against a token-level model.
module tb_boot_hex_stream_loader;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_char;
  logic        in_valid;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  boot_hex_stream_loader #(
    .address_width(32),
    .data_width(32),
    .char_width(8),
    .addr_increment(4),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_char(in_char),
    .in_valid(in_valid),
    .out_address(out_address),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .error(error)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word: got %h@%h expected none",
                 out_data, out_address);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_address, out_data} !== mon_e) begin
          errors++;
          $display("FAIL word: got %h@%h expected %h@%h",
                   out_data, out_address, mon_e[31:0], mon_e[63:32]);
        end
      end
    end
  end

  // Reference model: token-level interpretation of the stream.
  string       m_tok;
  bit          m_com;
  bit          m_err;
  logic [31:0] m_addr;

  function automatic bit is_sepc(byte c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0d || c == 8'h0a;
  endfunction

  function automatic bit parse(input string s, output logic [31:0] v);
    byte c;
    int n;
    v = 0;
    if (s.len() < 1 || s.len() > 8) return 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") n = c - "0";
      else if (c >= "a" && c <= "f") n = c - "a" + 10;
      else if (c >= "A" && c <= "F") n = c - "A" + 10;
      else return 0;
      v = v * 16 + 32'(n);
    end
    return 1;
  endfunction

  task automatic model_token();
    logic [31:0] v;
    bit ok;
    if (m_tok.len() == 0) return;
    if (m_tok[0] == "@") begin
      ok = parse(m_tok.substr(1, m_tok.len() - 1), v);
      if (ok) m_addr = v;
      else m_err = 1;
    end else begin
      ok = parse(m_tok, v);
      if (ok) begin
        exp_q.push_back({m_addr, v});
        m_addr = m_addr + 32'd4;
      end else m_err = 1;
    end
  endtask

  task automatic model_char(byte c);
    if (m_err) return;
    if (m_com) begin
      if (c == 8'h0a) m_com = 0;
      return;
    end
    if (is_sepc(c)) begin
      model_token();
      m_tok = "";
    end else if (m_tok == "/" && c == "/") begin
      m_com = 1;
      m_tok = "";
    end else begin
      m_tok = $sformatf("%s%c", m_tok, c);
    end
  endtask

  task automatic model_end();
    m_tok  = "";
    m_com  = 0;
    m_err  = 0;
    m_addr = 0;
  endtask

  task automatic send(byte c);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive(string s, bit use_model, int gmax);
    int g;
    for (int i = 0; i < s.len(); i++) begin
      if (use_model) model_char(s[i]);
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      send(s[i]);
    end
  endtask

  task automatic wait_end(output int pulses, output int first,
                          output int bfall);
    pulses = 0;
    first  = -1;
    bfall  = -1;
    for (int k = 1; k <= TO + 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (!busy && bfall < 0) bfall = k;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic string hexstr(int n);
    string digs = "0123456789abcdefABCDEF";
    string r = "";
    for (int i = 0; i < n; i++)
      r = $sformatf("%s%c", r, digs[$urandom_range(21, 0)]);
    return r;
  endfunction

  function automatic string rsep();
    case ($urandom_range(3, 0))
      0: return " ";
      1: return "\t";
      2: return "\r";
      default: return "\n";
    endcase
  endfunction

  function automatic string badtok();
    case ($urandom_range(5, 0))
      0: return "G1";
      1: return "/x";
      2: return "@";
      3: return "12@3";
      4: return "4/";
      default: return "@123456789";
    endcase
  endfunction

  function automatic string junk();
    string pool = " x@G/#1\t";
    string r = "";
    int n = $urandom_range(5, 0);
    for (int i = 0; i < n; i++)
      r = $sformatf("%s%c", r, pool[$urandom_range(7, 0)]);
    return r;
  endfunction

  function automatic string gen_session();
    string s = "";
    string tok;
    int r;
    int nt = $urandom_range(8, 2);
    for (int t = 0; t < nt; t++) begin
      r = $urandom_range(99, 0);
      if (r < 55) tok = hexstr($urandom_range(8, 1));
      else if (r < 72) tok = {"@", hexstr($urandom_range(8, 1))};
      else if (r < 82) tok = {"//", junk(), "\n"};
      else if (r < 86) tok = hexstr(9);
      else if (r < 90) tok = badtok();
      else tok = {"@FFFFFFF", hexstr(1)};
      s = {s, tok, rsep()};
    end
    return s;
  endfunction

  int p, f, b;
  string ss;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    model_end();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_addr", 64'(out_address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    exp_q.push_back({32'h10, 32'hDEADBEEF});
    exp_q.push_back({32'h14, 32'h00000012});
    drive("@10\nDEADBEEF 12\n", 0, 0);
    chk("basic_err", 64'(error), 64'd0);
    wait_end(p, f, b);
    chk("basic_done", 64'(p), 64'd1);
    chk("basic_drain", 64'(exp_q.size()), 64'd0);

    exp_q.push_back({32'h0, 32'h7});
    drive("// x@G\n7\n", 0, 0);
    chk("comment_err", 64'(error), 64'd0);
    wait_end(p, f, b);
    chk("comment_done", 64'(p), 64'd1);
    chk("comment_drain", 64'(exp_q.size()), 64'd0);

    drive("123456789\n", 0, 0);
    chk("long_err", 64'(error), 64'd1);
    chk("long_valid", 64'(out_valid), 64'd0);
    wait_end(p, f, b);
    chk("long_done", 64'(p), 64'd0);
    chk("long_errclr", 64'(error), 64'd0);

    out_ready = 1'b0;
    exp_q.push_back({32'h0, 32'h1});
    drive("1 2 ", 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ovr_valid", 64'(out_valid), 64'd1);
    chk("ovr_data", 64'(out_data), 64'd1);
    chk("ovr_addr", 64'(out_address), 64'd0);
    chk("ovr_err", 64'(error), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_accept", 64'(out_valid), 64'd0);
    chk("ovr_drain", 64'(exp_q.size()), 64'd0);
    wait_end(p, f, b);
    chk("ovr_done", 64'(p), 64'd0);

    exp_q.push_back({32'hFFFFFFFC, 32'hA});
    exp_q.push_back({32'h00000000, 32'hB});
    drive("@FFFFFFFC\nA B\n", 0, 0);
    wait_end(p, f, b);
    chk("wrap_drain", 64'(exp_q.size()), 64'd0);
    chk("wrap_done", 64'(p), 64'd1);

    exp_q.push_back({32'h0, 32'h5});
    drive("5\n", 0, 0);
    chk("to_busy", 64'(busy), 64'd1);
    wait_end(p, f, b);
    chk("to_done_cnt", 64'(p), 64'd1);
    chk("to_done_at", 64'(f), 64'(TO));
    chk("to_busy_fall", 64'(b), 64'(TO));

    exp_q.push_back({32'h0, 32'h3});
    exp_q.push_back({32'h0, 32'h9});
    drive("12", 0, 0);
    pulse_reset();
    chk("midrst_busy", 64'(busy), 64'd0);
    drive(" 3\n", 0, 0);
    drive("//ab", 0, 0);
    pulse_reset();
    drive("9\n", 0, 0);
    wait_end(p, f, b);
    chk("midrst_drain", 64'(exp_q.size()), 64'd0);
    chk("midrst_done", 64'(p), 64'd1);

    for (int n = 0; n < 30; n++) begin
      model_end();
      ss = gen_session();
      drive(ss, 1, 3);
      chk("rnd_err", 64'(error), 64'(m_err));
      wait_end(p, f, b);
      chk("rnd_done", 64'(p), 64'(!m_err));
      chk("rnd_drain", 64'(exp_q.size()), 64'd0);
      if (exp_q.size() != 0) exp_q.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_hex_stream_loader.md
BOOT_HEX_STREAM_LOADER -- requirements
Module: boot_hex_stream_loader

Interface
REQ-001 SHALL have parameter address_width, default 32, width of the load address.
REQ-002 SHALL have parameter data_width, default 32, word width; a multiple of 4.
REQ-003 SHALL have parameter char_width, default 8, input character width.
REQ-004 SHALL have parameter addr_increment, default data_width/8, added to the address after each emitted word.
REQ-005 SHALL have parameter timeout_cycles, default 50000000, number of idle clocks that ends a session.
REQ-006 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-008 SHALL have port in_char, input, char_width bits, ASCII character.
REQ-009 SHALL have port in_valid, input, 1 bit, in_char valid this cycle; no backpressure is applied to the input.
REQ-010 SHALL have port out_address, output, address_width bits, address of the emitted word.
REQ-011 SHALL have port out_data, output, data_width bits, emitted word.
REQ-012 SHALL have port out_valid, output, 1 bit, word available.
REQ-013 SHALL have port out_ready, input, 1 bit, consumer accepts the word.
REQ-014 SHALL have port busy, output, 1 bit, session active (timeout counter nonzero).
REQ-015 SHALL have port done, output, 1 bit, one-cycle pulse at error-free session end.
REQ-016 SHALL have port error, output, 1 bit, sticky parse or overrun error.

Function
REQ-017 Character classes SHALL be: hex = 0-9, a-f, A-F; separator = space, TAB, CR, LF; '@'; '/'; every other character is illegal.
REQ-018 FSM states SHALL be IDLE, DATA, ADDR, SLASH, COMMENT, ERR.
REQ-019 IDLE SHALL handle, per character: hex -> DATA, accumulator = nibble, count = 1; '@' -> ADDR, accumulator cleared, count = 0; '/' -> SLASH; separator -> stay; illegal -> ERR.
REQ-020 DATA SHALL handle: hex -> accumulator = (accumulator << 4) | nibble, count + 1; separator -> emit word, then IDLE.
REQ-021 DATA SHALL treat '@', '/', an illegal character, or a count exceeding data_width/4 as an error -> ERR.
REQ-022 ADDR SHALL handle: hex -> accumulate; separator with count >= 1 -> address = accumulator, then IDLE.
REQ-023 ADDR SHALL treat a separator with count 0, or a count exceeding address_width/4, as an error -> ERR; ADDR SHALL likewise treat any other non-hex character as an error -> ERR.
REQ-024 SLASH SHALL go to COMMENT on '/' and to ERR on any other character.
REQ-025 COMMENT SHALL discard all characters and return to IDLE on LF.
REQ-026 An emitted word SHALL be the accumulator zero-extended and right-aligned (short tokens are allowed); out_address SHALL be the current address.
REQ-027 After each emission, address SHALL become address + addr_increment, modulo 2^address_width (wraps silently).
REQ-028 out_valid SHALL rise in the cycle after the terminating separator is accepted.
REQ-029 out_valid, out_data and out_address SHALL hold until out_valid && out_ready.
REQ-030 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, error SHALL be set, and the FSM SHALL go to ERR; the pending word SHALL remain valid.
REQ-031 If a word completes in the same cycle as the pending word is accepted (out_ready=1), the new word SHALL be loaded with no gap and no error.
REQ-032 In ERR, error SHALL be 1 and all characters SHALL be ignored; no further words SHALL be emitted.
REQ-033 The timeout counter SHALL load timeout_cycles on in_valid and otherwise decrement while nonzero.
REQ-034 busy SHALL equal (counter != 0).
REQ-035 The session-end event SHALL be: counter == 1 and in_valid == 0.
REQ-036 At session end: FSM -> IDLE, accumulator cleared, address = 0, error cleared.
REQ-037 At session end, done SHALL pulse for 1 cycle only if error was 0; any pending out_valid SHALL be unaffected.
REQ-038 A character arriving on the session-end cycle SHALL not occur (in_valid reloads the counter); in_valid SHALL take priority.

Reset
REQ-039 On reset: FSM = IDLE, counter = 0, address = 0, accumulator = 0, out_valid = 0, out_data = 0, out_address = 0, busy = 0, done = 0, error = 0.
REQ-040 Reset asserted mid-token or mid-comment SHALL discard all partial state.

Verification
REQ-041 "@10\n" then "DEADBEEF 12\n", out_ready=1 -> words (0x10, 0xDEADBEEF) and (0x14, 0x00000012).
REQ-042 "// x@G\n" then "7\n" -> single word (0x0, 0x7), error=0.
REQ-043 "123456789\n" (9 nibbles, data_width=32) -> error=1, no output; idle for timeout_cycles -> error=0, done=0.
REQ-044 out_ready=0, "1 2 " -> word 1 held, error=1, word 2 never appears; out_ready=1 -> word 1 accepted.
REQ-045 "@FFFFFFFC\n" then "A B\n" -> addresses 0xFFFFFFFC, then 0x00000000.
REQ-046 "5\n", then idle timeout_cycles with timeout_cycles=100 -> busy falls and done pulses once exactly 100 cycles after the last in_valid.
